alu_seq: RTL and testbench

Parametrised, registered successor to the core's combinational ALU. It adds XOR, set-less-than (signed and unsigned) and the three shifts. It wraps the datapath in a request/response handshake so the execute stage can stall on it. Shifts run iteratively, SHIFT_STEP bit positions per cycle, which keeps the barrel-shifter area out of small configurations. All other operations complete in one registered cycle.

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a request/response handshake.
// Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLTU.
// Shifts (SLL, SRL, SRA) move at most SHIFT_STEP bit positions per cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous abort; drops any in-flight op or pending response
//   req_valid/ready   request handshake; op1, op2, alu_func sampled on transfer
//   resp_valid/ready  response handshake; alu_out, zero, illegal held while resp_valid
module alu_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_func,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam logic [SHAMT_W:0] StepK = (SHAMT_W + 1)'(SHIFT_STEP);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

  state_e             state_q, state_d;
  shift_e             shop_q, shop_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [XLEN-1:0]    alu_out_q, alu_out_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic               resp_valid_q, resp_valid_d;

  logic               accept;
  logic [XLEN-1:0]    res_c;
  logic               ill_c;
  logic               is_shift;
  shift_e             shop_c;
  logic [SHAMT_W-1:0] shamt_in;
  logic [SHAMT_W:0]   step_k;
  logic [XLEN-1:0]    shifted;
  logic [SHAMT_W-1:0] rem_next;

  // Gated by rst so no transfer is advertised while reset is held.
  assign req_ready = !rst && !flush &&
                     ((state_q == StIdle) || ((state_q == StDone) && resp_ready));
  assign accept    = req_valid && req_ready;
  assign shamt_in  = op2[SHAMT_W-1:0];

  // Single-cycle datapath and shift decode.
  always_comb begin
    res_c    = '0;
    ill_c    = 1'b0;
    is_shift = 1'b0;
    shop_c   = ShSll;
    case (alu_func)
      AluAdd:  res_c = op1 + op2;
      AluSub:  res_c = op1 - op2;
      AluAnd:  res_c = op1 & op2;
      AluOr:   res_c = op1 | op2;
      AluXor:  res_c = op1 ^ op2;
      AluSlt:  res_c = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      AluSltu: res_c = {{(XLEN-1){1'b0}}, (op1 < op2)};
      AluSll:  begin is_shift = 1'b1; shop_c = ShSll; end
      AluSrl:  begin is_shift = 1'b1; shop_c = ShSrl; end
      AluSra:  begin is_shift = 1'b1; shop_c = ShSra; end
      default: ill_c = 1'b1;
    endcase
  end

  // One iterative shift step of min(SHIFT_STEP, remaining) positions.
  // The sign bit of work_q stays op1's MSB under SRA, so it serves as the fill.
  always_comb begin
    step_k  = ({1'b0, rem_q} >= StepK) ? StepK : {1'b0, rem_q};
    shifted = work_q;
    case (shop_q)
      ShSll:   shifted = work_q << step_k;
      ShSrl:   shifted = work_q >> step_k;
      default: shifted = $signed(work_q) >>> step_k;
    endcase
    // step_k never exceeds rem_q, so the truncation is lossless.
    rem_next = rem_q - step_k[SHAMT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    shop_d       = shop_q;
    work_d       = work_q;
    rem_d        = rem_q;
    alu_out_d    = alu_out_q;
    illegal_d    = illegal_q;
    resp_valid_d = resp_valid_q;

    if (flush) begin
      state_d      = StIdle;
      resp_valid_d = 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        work_d = op1;
        rem_d  = shamt_in;
        shop_d = shop_c;
        if (shamt_in == '0) begin
          state_d      = StDone;
          alu_out_d    = op1;
          illegal_d    = 1'b0;
          resp_valid_d = 1'b1;
        end else begin
          state_d      = StShift;
          resp_valid_d = 1'b0;
        end
      end else begin
        state_d      = StDone;
        alu_out_d    = res_c;
        illegal_d    = ill_c;
        resp_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        StShift: begin
          work_d = shifted;
          rem_d  = rem_next;
          if (rem_next == '0) begin
            state_d      = StDone;
            alu_out_d    = shifted;
            illegal_d    = 1'b0;
            resp_valid_d = 1'b1;
          end
        end
        StDone: begin
          if (resp_ready) begin
            state_d      = StIdle;
            resp_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    zero_d = (alu_out_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shop_q       <= ShSll;
      work_q       <= '0;
      rem_q        <= '0;
      alu_out_q    <= '0;
      zero_q       <= 1'b1;
      illegal_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shop_q       <= shop_d;
      work_q       <= work_d;
      rem_q        <= rem_d;
      alu_out_q    <= alu_out_d;
      zero_q       <= zero_d;
      illegal_q    <= illegal_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign alu_out    = alu_out_q;
  assign zero       = zero_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam logic [3:0] FAdd  = 4'd0;
  localparam logic [3:0] FSub  = 4'd1;
  localparam logic [3:0] FAnd  = 4'd2;
  localparam logic [3:0] FOr   = 4'd3;
  localparam logic [3:0] FXor  = 4'd4;
  localparam logic [3:0] FSlt  = 4'd5;
  localparam logic [3:0] FSltu = 4'd6;
  localparam logic [3:0] FSll  = 4'd7;
  localparam logic [3:0] FSrl  = 4'd8;
  localparam logic [3:0] FSra  = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, req_valid, req_valid4, resp_ready;
  logic [31:0] op1, op2;
  logic [3:0]  alu_func;
  logic        req_ready, resp_valid, zero, illegal;
  logic [31:0] alu_out;
  logic        req_ready4, resp_valid4, zero4, illegal4;
  logic [31:0] alu_out4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] out;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        ill;
    int          lat;
  } vec_t;
  vec_t vecs[15];

  alu_seq #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op1        (op1),
    .op2        (op2),
    .alu_func   (alu_func),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .alu_out    (alu_out),
    .zero       (zero),
    .illegal    (illegal)
  );

  alu_seq #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid4),
    .req_ready  (req_ready4),
    .op1        (op1),
    .op2        (op2),
    .alu_func   (alu_func),
    .resp_valid (resp_valid4),
    .resp_ready (resp_ready),
    .alu_out    (alu_out4),
    .zero       (zero4),
    .illegal    (illegal4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a response is consumed when resp_valid && resp_ready and no flush.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready && !flush) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got 0x%0h, want no response", alu_out);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_out", alu_out, mon_e.out);
        chk("resp_illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
        chk("resp_zero", {31'b0, zero}, {31'b0, (mon_e.out == 32'd0)});
      end
    end
  end

  // Drive one request on the main DUT and wait for its transfer edge.
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input bit push, input logic [31:0] eo, input logic ei);
    int n = 0;
    @(posedge clk); #1;
    alu_func  = f;
    op1       = a;
    op2       = b;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("req_accept", {31'b0, req_ready}, 32'd1);
    if (push) sb.push_back('{out: eo, ill: ei});
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble operands: the DUT must have sampled them at the transfer.
    op1       = $urandom;
    op2       = $urandom;
    alu_func  = 4'($urandom_range(15, 0));
  endtask

  task automatic run_one(input vec_t v);
    int lat = 0;
    bit rdy_seen = 0;
    send(v.f, v.a, v.b, 1'b1, v.out, v.ill);
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid && req_ready) rdy_seen = 1'b1;
    end while (!resp_valid && lat < 100);
    chk("latency", lat, v.lat);
    chk("ready_low_busy", {31'b0, rdy_seen}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  rv_seen;
    vec_t v;

    vecs[0]  = '{f: FAdd,  a: 32'hFFFF_FFFF, b: 32'h1,         out: 32'h0,         ill: 0, lat: 1};
    vecs[1]  = '{f: FSlt,  a: 32'h8000_0000, b: 32'h1,         out: 32'h1,         ill: 0, lat: 1};
    vecs[2]  = '{f: FSltu, a: 32'h8000_0000, b: 32'h1,         out: 32'h0,         ill: 0, lat: 1};
    vecs[3]  = '{f: FSra,  a: 32'h8000_0000, b: 32'h1F,        out: 32'hFFFF_FFFF, ill: 0, lat: 32};
    vecs[4]  = '{f: FSll,  a: 32'h1,         b: 32'h24,        out: 32'h10,        ill: 0, lat: 5};
    vecs[5]  = '{f: 4'd12, a: 32'h1234_5678, b: 32'h9,         out: 32'h0,         ill: 1, lat: 1};
    vecs[6]  = '{f: FAnd,  a: 32'hF0F0_00FF, b: 32'h0FF0_0F0F, out: 32'h00F0_000F, ill: 0, lat: 1};
    vecs[7]  = '{f: FSub,  a: 32'h5,         b: 32'h7,         out: 32'hFFFF_FFFE, ill: 0, lat: 1};
    vecs[8]  = '{f: FSrl,  a: 32'h8000_0000, b: 32'h4,         out: 32'h0800_0000, ill: 0, lat: 5};
    vecs[9]  = '{f: FSll,  a: 32'h1234_5678, b: 32'h20,        out: 32'h1234_5678, ill: 0, lat: 1};
    vecs[10] = '{f: FSra,  a: 32'h4000_0000, b: 32'h2,         out: 32'h1000_0000, ill: 0, lat: 3};
    vecs[11] = '{f: FXor,  a: 32'hA5A5_A5A5, b: 32'hFFFF_FFFF, out: 32'h5A5A_5A5A, ill: 0, lat: 1};
    vecs[12] = '{f: FSlt,  a: 32'h5,         b: 32'hFFFF_FFFF, out: 32'h0,         ill: 0, lat: 1};
    vecs[13] = '{f: FSltu, a: 32'h5,         b: 32'hFFFF_FFFF, out: 32'h1,         ill: 0, lat: 1};
    vecs[14] = '{f: 4'd15, a: 32'h1,         b: 32'h1,         out: 32'h0,         ill: 1, lat: 1};

    flush = 0; req_valid = 0; req_valid4 = 0; resp_ready = 1;
    op1 = 0; op2 = 0; alu_func = 0;

    // Reset values while rst is held.
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 15; i++) run_one(vecs[i]);

    // Back-to-back single-cycle ops with resp_ready held high.
    @(posedge clk); #1;
    alu_func = FXor; op1 = 32'hF0F0_F0F0; op2 = 32'hFFFF_0000; req_valid = 1;
    sb.push_back('{out: 32'h0F0F_F0F0, ill: 1'b0});
    @(posedge clk); #1;
    alu_func = FOr; op1 = 32'h1; op2 = 32'h2;
    sb.push_back('{out: 32'h3, ill: 1'b0});
    @(negedge clk);
    chk("b2b_valid_1", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    alu_func = FSub; op1 = 32'h0; op2 = 32'h1;
    sb.push_back('{out: 32'hFFFF_FFFF, ill: 1'b0});
    @(negedge clk);
    chk("b2b_valid_2", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    req_valid = 0; resp_ready = 0;
    @(negedge clk);
    chk("b2b_valid_3", {31'b0, resp_valid}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_out", alu_out, 32'hFFFF_FFFF);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    @(negedge clk);
    chk("done_ready_follows", {31'b0, req_ready}, 32'd1);

    // SHIFT_STEP=4 instance: SRA by 31 takes 1 + ceil(31/4) = 9 cycles.
    @(posedge clk); #1;
    alu_func = FSra; op1 = 32'h8000_0000; op2 = 32'h1F; req_valid4 = 1;
    @(negedge clk);
    chk("step4_accept", {31'b0, req_ready4}, 32'd1);
    @(posedge clk); #1;
    req_valid4 = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid4 && lat < 100);
    chk("step4_latency", lat, 9);
    chk("step4_out", alu_out4, 32'hFFFF_FFFF);
    chk("step4_illegal", {31'b0, illegal4}, 32'd0);
    chk("step4_zero", {31'b0, zero4}, 32'd0);

    // Flush on cycle 5 of a 32-cycle SRL: no response may ever appear.
    send(FSrl, 32'hFFFF_FFFF, 32'h1F, 1'b0, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    chk("flush_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_hold_out", alu_out, 32'hFFFF_FFFF);
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1;
    end
    chk("flush_no_resp", {31'b0, rv_seen}, 32'd0);
    v = '{f: FAdd, a: 32'h5, b: 32'h6, out: 32'hB, ill: 0, lat: 1};
    run_one(v);

    // Flush coinciding with a response handshake: flush wins.
    @(posedge clk); #1;
    resp_ready = 0;
    send(FXor, 32'h0F, 32'hF0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pend_valid", {31'b0, resp_valid}, 32'd1);
    chk("pend_out", alu_out, 32'hFF);
    @(posedge clk); #1;
    flush = 1; resp_ready = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_hs_valid", {31'b0, resp_valid}, 32'd0);
    chk("flush_hs_hold", alu_out, 32'hFF);

    // Asynchronous reset in the middle of a shift.
    send(FSll, 32'h1, 32'h1F, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("async_rst_out", alu_out, 32'd0);
    chk("async_rst_zero", {31'b0, zero}, 32'd1);
    chk("async_rst_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
    v = '{f: FAdd, a: 32'h2, b: 32'h3, out: 32'h5, ill: 0, lat: 1};
    run_one(v);

    @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
